// File: rtl/traffic_interval_timer_if.sv
// rtl/traffic_interval_timer_if.sv - request/program/status bundle between the light FSM and the interval timer
interface traffic_interval_timer_if;
    logic       start_timer;
    logic [1:0] interval;
    logic       Prog_Sync;
    logic [1:0] time_param;
    logic [3:0] time_value;
    logic       expired;
    logic       running;
    logic [3:0] remaining;

    modport master (
        output start_timer, interval, Prog_Sync, time_param, time_value,
        input  expired, running, remaining
    );

    modport slave (
        input  start_timer, interval, Prog_Sync, time_param, time_value,
        output expired, running, remaining
    );
endinterface

// File: rtl/traffic_interval_timer.sv
// rtl/traffic_interval_timer.sv - programmable seconds countdown with one-cycle expiry pulse
module traffic_interval_timer #(
    parameter int         CLK_DIV  = 1000,
    parameter logic [3:0] BASE_DEF = 4'd6,
    parameter logic [3:0] EXT_DEF  = 4'd3,
    parameter logic [3:0] YEL_DEF  = 4'd2
) (
    input  logic                         clk,
    input  logic                         Reset_n,
    traffic_interval_timer_if.slave      bus
);
    localparam int          PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [3:0]    base_t;
    logic [3:0]    ext_t;
    logic [3:0]    yel_t;
    logic [3:0]    wr_val;
    logic [3:0]    sel_t;
    logic [PW-1:0] presc;
    logic [3:0]    remaining_q;
    logic          running_q;
    logic          expired_q;

    // Zero durations are promoted to one second so a count always elapses.
    always_comb begin
        wr_val = (bus.time_value == 4'd0) ? 4'd1 : bus.time_value;
    end

    // Duration chosen by the start request; code 11 falls back to base.
    always_comb begin
        case (bus.interval)
            2'b01:   sel_t = ext_t;
            2'b10:   sel_t = yel_t;
            default: sel_t = base_t;
        endcase
    end

    // Duration registers; a start in the same cycle still sees the old value.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            base_t <= BASE_DEF;
            ext_t  <= EXT_DEF;
            yel_t  <= YEL_DEF;
        end else if (bus.Prog_Sync) begin
            case (bus.time_param)
                2'b00:   base_t <= wr_val;
                2'b01:   ext_t  <= wr_val;
                2'b10:   yel_t  <= wr_val;
                default: ;
            endcase
        end
    end

    // Prescaler and seconds countdown; a start always wins over the tick.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            presc       <= '0;
            remaining_q <= 4'd0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (bus.start_timer) begin
                presc       <= '0;
                remaining_q <= sel_t;
                running_q   <= 1'b1;
            end else if (running_q) begin
                if (presc == PRESC_MAX) begin
                    presc       <= '0;
                    remaining_q <= remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                presc <= '0;
            end
        end
    end

    assign bus.expired   = expired_q;
    assign bus.running   = running_q;
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_traffic_interval_timer.sv
// tb/tb_traffic_interval_timer.sv - scoreboard bench for traffic_interval_timer
module tb_traffic_interval_timer;
    localparam int DIV = 4;

    logic clk;
    logic Reset_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   exp_q[$];
    logic prev_exp;

    traffic_interval_timer_if tif ();

    traffic_interval_timer #(
        .CLK_DIV  (DIV),
        .BASE_DEF (4'd6),
        .EXT_DEF  (4'd3),
        .YEL_DEF  (4'd2)
    ) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every expiry pulse must match the oldest expected expiry cycle.
    always @(negedge clk) begin
        if (!Reset_n) begin
            prev_exp = 1'b0;
        end else begin
            if (tif.expired) begin
                if (prev_exp) chk("expired_double", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("expired_unexpected", 1, 0);
                end else begin
                    chk("expire_cycle", cyc, exp_q.pop_front());
                end
            end
            prev_exp = tif.expired;
        end
    end

    // Issue a start; any pending count is aborted and must never expire.
    task automatic do_start(input logic [1:0] iv, input int secs);
        tif.start_timer = 1'b1;
        tif.interval    = iv;
        exp_q.delete();
        exp_q.push_back(cyc + 1 + secs * DIV);
        @(negedge clk);
        tif.start_timer = 1'b0;
        tif.interval    = 2'b11;
    endtask

    task automatic prog(input logic [1:0] p, input logic [3:0] v);
        tif.Prog_Sync  = 1'b1;
        tif.time_param = p;
        tif.time_value = v;
        @(negedge clk);
        tif.Prog_Sync  = 1'b0;
        tif.time_param = 2'b11;
        tif.time_value = 4'd0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        chk({name, "_idle_running"}, int'(tif.running), 0);
        chk({name, "_idle_remaining"}, int'(tif.remaining), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        prev_exp = 1'b0;
        tif.start_timer = 1'b0;
        tif.interval    = 2'b00;
        tif.Prog_Sync   = 1'b0;
        tif.time_param  = 2'b11;
        tif.time_value  = 4'd0;
        Reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_expired", int'(tif.expired), 0);
        chk("reset_running", int'(tif.running), 0);
        chk("reset_remaining", int'(tif.remaining), 0);
        Reset_n = 1'b1;
        @(negedge clk);

        // Default base count: remaining steps 6..0, running drops with expired.
        do_start(2'b00, 6);
        chk("base_rem_start", int'(tif.remaining), 6);
        chk("base_run_start", int'(tif.running), 1);
        for (int k = 1; k <= 6; k++) begin
            repeat (DIV) @(negedge clk);
            chk("base_rem_step", int'(tif.remaining), 6 - k);
        end
        chk("base_run_end", int'(tif.running), 0);
        chk("base_exp_end", int'(tif.expired), 1);
        wait_idle("base", 60);

        // Program ext to 5, then interval 11 falls back to base.
        prog(2'b01, 4'd5);
        do_start(2'b01, 5);
        wait_idle("ext5", 60);
        do_start(2'b11, 6);
        wait_idle("iv11", 60);

        // Restart mid-count with yellow (default 2 s).
        do_start(2'b00, 6);
        repeat (9) @(negedge clk);
        do_start(2'b10, 2);
        chk("restart_rem", int'(tif.remaining), 2);
        wait_idle("restart_mid", 60);

        // Restart landing on the expiry edge suppresses the pulse.
        do_start(2'b00, 6);
        repeat (23) @(negedge clk);
        do_start(2'b10, 2);
        wait_idle("restart_exp", 60);

        // Program and start together: this count uses 6, next uses 9.
        tif.Prog_Sync   = 1'b1;
        tif.time_param  = 2'b00;
        tif.time_value  = 4'd9;
        do_start(2'b00, 6);
        tif.Prog_Sync   = 1'b0;
        tif.time_param  = 2'b11;
        tif.time_value  = 4'd0;
        wait_idle("simul_old", 60);
        do_start(2'b00, 9);
        wait_idle("simul_new", 80);

        // Zero write stored as 1; select 11 writes nothing.
        prog(2'b10, 4'd0);
        do_start(2'b10, 1);
        wait_idle("yel_zero", 30);
        prog(2'b11, 4'd15);
        do_start(2'b00, 9);
        wait_idle("nowr_base", 80);
        do_start(2'b01, 5);
        wait_idle("nowr_ext", 60);
        do_start(2'b10, 1);
        wait_idle("nowr_yel", 30);

        // Asynchronous reset mid-count.
        do_start(2'b00, 9);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2;
        Reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("areset_running", int'(tif.running), 0);
        chk("areset_remaining", int'(tif.remaining), 0);
        chk("areset_expired", int'(tif.expired), 0);
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        repeat (50) @(negedge clk);

        // Defaults restored by reset.
        do_start(2'b00, 6);
        wait_idle("def_base", 60);
        do_start(2'b01, 3);
        wait_idle("def_ext", 40);
        do_start(2'b10, 2);
        wait_idle("def_yel", 30);

        chk("pending_expiries", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_interval_timer.md
# traffic_interval_timer

Programmable interval timer serving the traffic-light controller FSM. It accepts a one-cycle `start_timer` request with a 2-bit `interval` code, counts the selected number of seconds, and returns a one-cycle `expired` pulse. It stores the three programmable durations (base, extended, yellow), reloaded through the synchronized `Prog_Sync` path. It sits between the FSM and the one-second timebase, so the controller is independent of the clock frequency.

## Interface
- `CLK_DIV`, default 1000: clock cycles per one-second tick; minimum 2.
- `BASE_DEF`, default 6: reset value of the base duration in seconds, 4-bit, 1..15.
- `EXT_DEF`, default 3: reset value of the extended duration in seconds, 4-bit, 1..15.
- `YEL_DEF`, default 2: reset value of the yellow duration in seconds, 4-bit, 1..15.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `start_timer`  in  1  one-cycle request to (re)start the countdown.
- `interval`  in  2  duration select, sampled with `start_timer`: 00 base, 01 ext, 10 yellow, 11 treated as base.
- `Prog_Sync`  in  1  one-cycle, already-synchronized program strobe.
- `time_param`  in  2  register select for programming: 00 base, 01 ext, 10 yellow, 11 no write.
- `time_value`  in  4  seconds value written on `Prog_Sync`.
- `expired`  out  1  one-cycle pulse when the countdown completes.
- `running`  out  1  high while a countdown is active.
- `remaining`  out  4  whole seconds left in the current countdown; 0 when idle.

## Operation
- Registers `base_t`, `ext_t` and `yel_t` (4-bit) reset to `BASE_DEF`, `EXT_DEF` and `YEL_DEF`.
- Programming:
  - When `Prog_Sync` is 1 and `time_param` is not 11, the selected register loads `time_value`.
  - A `time_value` of 0 is stored as 1, so every duration is at least 1 s.
- Start:
  - When `start_timer` is 1, `remaining` loads the register selected by `interval`, the prescaler clears to 0, and `running` is set to 1.
  - If `Prog_Sync` and `start_timer` occur in the same cycle, the start uses the register value from before the write. The new value applies from the next start.
- Count:
  - While `running` is 1, the prescaler counts 0..`CLK_DIV`-1.
  - At `CLK_DIV`-1 the prescaler wraps to 0 and `remaining` decrements.
  - The decrement from 1 to 0 clears `running` and asserts `expired` for exactly one cycle.
- Idle:
  - The prescaler holds at 0, `remaining` is 0, and `expired` is 0.
  - `interval` is ignored without `start_timer`.
- Restart wins:
  - A `start_timer` while `running` is 1 discards the current count and reloads. No `expired` is issued for the aborted count.
  - If `start_timer` arrives in the cycle the count would expire, the reload happens and `expired` is not asserted.
- `expired` never stays high for two consecutive cycles. This prevents the FSM from double-advancing.

## Timing
- Reset values: `expired`=0, `running`=0, `remaining`=0, prescaler=0, and the three registers at their defaults.
- An asynchronous assert of `Reset_n` mid-count aborts the count immediately, with no `expired` pulse.
- Latency:
  - `start_timer` is sampled high at edge E0 with selected duration N.
  - `expired` is high in the cycle following edge E0 + N·`CLK_DIV`.
  - `running` is high from E0 to E0 + N·`CLK_DIV`.
- `remaining` updates on the tick edge. It reads N immediately after E0 and N−k after the k-th tick.
- A programming write is visible in the register one cycle after the `Prog_Sync` edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Default base with `CLK_DIV`=4: after reset, pulse `start_timer` with `interval`=00 at E0. Required: `expired` is high for one cycle after E0+24, `remaining` steps 6,5,…,0, and `running` drops with `expired`.
- Program, then start: `Prog_Sync` with `time_param`=01 and `time_value`=5, then start with `interval`=01. Required: `expired` after 20 cycles. Also start with `interval`=11, which must give 24 cycles (base).
- Zero write and no-write select:
  - Program `time_param`=10 with `time_value`=0, then start with `interval`=10. Required: `expired` after 4 cycles.
  - A write with `time_param`=11 must change no register.
- Restart mid-count: start the base count, then re-pulse `start_timer` with `interval`=10 at cycle 10. Required: no `expired` near cycle 24, and `expired` after 8 cycles from the restart. Also repeat with the restart landing in the expiry cycle; `expired` must not pulse.
- Simultaneous program and start: `Prog_Sync` (00, value 9) in the same cycle as `start_timer` with `interval`=00. Required: this count uses 6 s (24 cycles), and the next start uses 9 s (36 cycles).
- Asynchronous reset mid-count: drop `Reset_n` between edges at cycle 13. Required: outputs are 0 immediately, there is no `expired`, and the registers return to their defaults.
